// File: rtl/transaccion_pkg.sv
// Shared definitions for the transaction-layer egress path:
// state encoding, default sizes and destination field position.
package transaccion_pkg;

    localparam int DEF_NUM_PORTS = 4;
    localparam int DEF_WORD_SIZE = 10;
    localparam int DEF_CNT_WIDTH = 5;
    localparam int PORT_W        = $clog2(DEF_NUM_PORTS);

    localparam int DEST_MSB = 9;
    localparam int DEST_LSB = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_POP     = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        POP     = ST_POP,
        CAPTURE = ST_CAPTURE,
        HOLD    = ST_HOLD
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: nearest requester after
// last_grant_i wins; the pointer register lives in the caller.
module rr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     last_grant_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic                 any_o
);

    logic [IDX_W-1:0] p;

    // Scan farthest-to-nearest so the nearest requester overwrites.
    always_comb begin
        grant_o = '0;
        p       = '0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            p = IDX_W'((int'(last_grant_i) + i) % NUM_PORTS);
            if (req_i[p]) begin
                grant_o    = '0;
                grant_o[p] = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/egress_reader.sv
// Drains the output FIFO bank round-robin onto a valid/ready
// stream and keeps saturating per-port delivered-word counters.
module egress_reader
    import transaccion_pkg::*;
#(
    parameter int NUM_PORTS      = DEF_NUM_PORTS,
    parameter int FIFO_WORD_SIZE = DEF_WORD_SIZE,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int IDX_W          = $clog2(NUM_PORTS)
) (
    input  logic                                clk,
    input  logic                                reset_L,
    input  logic [NUM_PORTS-1:0]                fifo_empty,
    input  logic [NUM_PORTS*FIFO_WORD_SIZE-1:0] fifo_data,
    output logic [NUM_PORTS-1:0]                pop_FIFO_out,
    output logic [FIFO_WORD_SIZE-1:0]           data_out,
    output logic                                valid_out,
    input  logic                                ready_in,
    input  logic                                req,
    input  logic [IDX_W-1:0]                    idx,
    output logic [CNT_WIDTH-1:0]                data,
    output logic                                valid
);

    state_e                    state_q, state_d;
    logic [NUM_PORTS-1:0]      pop_q, pop_d;
    logic [NUM_PORTS-1:0]      grant_oh;
    logic                      any_grant;
    logic [IDX_W-1:0]          grant_idx;
    logic [IDX_W-1:0]          last_grant_q, last_grant_d;
    logic [FIFO_WORD_SIZE-1:0] data_out_q, data_out_d;
    logic                      valid_out_q, valid_out_d;
    logic [CNT_WIDTH-1:0]      count_q [NUM_PORTS];
    logic [CNT_WIDTH-1:0]      count_d [NUM_PORTS];
    logic [CNT_WIDTH-1:0]      rd_data_q, rd_data_d;
    logic                      rd_valid_q, rd_valid_d;
    logic [FIFO_WORD_SIZE-1:0] words [NUM_PORTS];

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_arb (
        .req_i        (~fifo_empty),
        .last_grant_i (last_grant_q),
        .grant_o      (grant_oh),
        .any_o        (any_grant)
    );

    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            words[k] = fifo_data[k*FIFO_WORD_SIZE +: FIFO_WORD_SIZE];
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (grant_oh[k]) grant_idx = IDX_W'(k);
        end
    end

    always_comb begin
        state_d      = state_q;
        pop_d        = '0;
        last_grant_d = last_grant_q;
        data_out_d   = data_out_q;
        valid_out_d  = valid_out_q;
        count_d      = count_q;
        // Counter read sees this cycle's value, before any increment.
        rd_data_d    = req ? count_q[idx] : '0;
        rd_valid_d   = req;
        unique case (state_q)
            IDLE: begin
                if (any_grant) begin
                    state_d      = POP;
                    pop_d        = grant_oh;
                    last_grant_d = grant_idx;
                end
            end
            POP: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                data_out_d  = words[last_grant_q];
                valid_out_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (ready_in) begin
                    valid_out_d = 1'b0;
                    state_d     = IDLE;
                    if (count_q[last_grant_q] != '1) begin
                        count_d[last_grant_q] = count_q[last_grant_q] + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= IDLE;
            pop_q        <= '0;
            last_grant_q <= IDX_W'(NUM_PORTS - 1);
            data_out_q   <= '0;
            valid_out_q  <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                count_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            pop_q        <= pop_d;
            last_grant_q <= last_grant_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            count_q      <= count_d;
        end
    end

    assign pop_FIFO_out = pop_q;
    assign data_out     = data_out_q;
    assign valid_out    = valid_out_q;
    assign data         = rd_data_q;
    assign valid        = rd_valid_q;

endmodule

// File: tb/tb_egress_reader.sv
// Bench for egress_reader: queue-based FIFO bank, round-robin
// delivery model and saturating counter model.
module tb_egress_reader;

    localparam int NP = 4;
    localparam int W  = 10;
    localparam int CW = 5;
    localparam int CMAX = 31;

    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic [NP-1:0] fifo_empty = '1;
    logic [NP*W-1:0] fifo_data;
    logic [NP-1:0] pop;
    logic [W-1:0]  data_out;
    logic          valid_out;
    logic          ready_in = 1'b0;
    logic          req = 1'b0;
    logic [1:0]    idx = '0;
    logic [CW-1:0] data;
    logic          valid;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] fq [NP][$];
    logic [W-1:0] rdata [NP] = '{default: '0};

    int           m_last;
    int           m_cnt [NP];
    int           exp_port [$];
    logic [W-1:0] exp_word [$];
    int           exp_hs_port [$];

    always #5 clk = ~clk;

    egress_reader dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .pop_FIFO_out (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .req          (req),
        .idx          (idx),
        .data         (data),
        .valid        (valid)
    );

    for (genvar k = 0; k < NP; k++) begin : g_fd
        assign fifo_data[k*W +: W] = rdata[k];
    end

    // FIFO bank: read data appears the cycle after a pop.
    always begin : fifo_model
        logic [NP-1:0] pv;
        @(posedge clk);
        pv = pop;
        #1;
        for (int k = 0; k < NP; k++) begin
            if (pv[k] && fq[k].size() > 0) rdata[k] = fq[k].pop_front();
            fifo_empty[k] = (fq[k].size() == 0);
        end
        @(negedge clk);
        #1;
        for (int k = 0; k < NP; k++) fifo_empty[k] = (fq[k].size() == 0);
    end

    task automatic model_clear();
        for (int k = 0; k < NP; k++) begin
            fq[k].delete();
            m_cnt[k] = 0;
        end
        m_last = NP - 1;
        exp_port.delete();
        exp_word.delete();
        exp_hs_port.delete();
    endtask

    // Delivery order for the words currently queued.
    task automatic build_expected();
        int pos [NP];
        int left;
        int p;
        left = 0;
        for (int k = 0; k < NP; k++) begin
            pos[k] = 0;
            left += fq[k].size();
        end
        while (left > 0) begin
            for (int i = 1; i <= NP; i++) begin
                p = (m_last + i) % NP;
                if (pos[p] < fq[p].size()) begin
                    exp_port.push_back(p);
                    exp_hs_port.push_back(p);
                    exp_word.push_back(fq[p][pos[p]]);
                    pos[p]++;
                    m_last = p;
                    left--;
                    break;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_L = 1'b0;
        req = 1'b0;
        ready_in = 1'b0;
        model_clear();
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic read_count(input int k, output logic [CW-1:0] d,
                              output logic v);
        @(negedge clk);
        req = 1'b1;
        idx = 2'(k);
        @(posedge clk);
        #1;
        d = data;
        v = valid;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        logic [CW-1:0] d;
        logic v;
        for (int k = 0; k < NP; k++) begin
            read_count(k, d, v);
            checks++;
            if (v !== 1'b1 || d !== CW'(m_cnt[k])) begin
                errors++;
                $display("FAIL %s cnt[%0d]: got %0d/v%b want %0d/v1",
                         tag, k, d, v, m_cnt[k]);
            end
        end
    endtask

    task automatic drain(input int n, input bit rnd);
        int got = 0;
        int budget = n * 40 + 40;
        bit holding = 0;
        logic [W-1:0] held = '0;
        int p;
        for (int c = 0; c < budget && got < n; c++) begin
            @(negedge clk);
            ready_in = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            checks++;
            if ((pop & (pop - 1'b1)) != 0 || (pop & fifo_empty) != 0) begin
                errors++;
                $display("FAIL pop_legal: pop=%b empty=%b", pop, fifo_empty);
            end
            if (pop != 0) begin
                checks++;
                if (exp_port.size() == 0) begin
                    errors++;
                    $display("FAIL extra_pop: pop=%b none expected", pop);
                end else begin
                    p = exp_port.pop_front();
                    if (pop !== NP'(1 << p)) begin
                        errors++;
                        $display("FAIL rr_order: pop=%b want %b",
                                 pop, NP'(1 << p));
                    end
                end
            end
            if (valid_out) begin
                if (holding) begin
                    checks++;
                    if (data_out !== held) begin
                        errors++;
                        $display("FAIL hold_stable: got %h want %h",
                                 data_out, held);
                    end
                end
                if (ready_in) begin
                    checks++;
                    p = exp_hs_port.pop_front();
                    if (data_out !== exp_word[0]) begin
                        errors++;
                        $display("FAIL deliver: got %h want %h (port %0d)",
                                 data_out, exp_word[0], p);
                    end
                    void'(exp_word.pop_front());
                    if (m_cnt[p] < CMAX) m_cnt[p]++;
                    got++;
                    holding = 0;
                end else begin
                    holding = 1;
                    held = data_out;
                end
            end
        end
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL drain_timeout: got %0d words want %0d", got, n);
        end
        @(negedge clk);
        ready_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (pop !== '0 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL drain_idle: pop=%b valid_out=%b want 0/0",
                     pop, valid_out);
        end
    endtask

    task automatic test_reset();
        model_clear();
        reset_L = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req = 1'($urandom);
            idx = 2'($urandom);
            ready_in = 1'($urandom);
            fq[$urandom_range(0, NP-1)].push_back(W'($urandom));
            #1;
            checks++;
            if (pop !== '0 || data_out !== '0 || valid_out !== 1'b0 ||
                data !== '0 || valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_outs: pop=%b do=%h vo=%b d=%0d v=%b",
                         pop, data_out, valid_out, data, valid);
            end
        end
        @(negedge clk);
        model_clear();
        req = 1'b0;
        ready_in = 1'b0;
        reset_L = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (pop !== '0 || valid_out !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: pop=%b vo=%b want 0/0",
                         pop, valid_out);
            end
        end
    endtask

    task automatic test_single();
        logic [CW-1:0] d;
        logic v;
        @(negedge clk);
        fq[2].push_back(10'h278);
        build_expected();
        exp_port.delete();
        exp_word.delete();
        exp_hs_port.delete();
        @(posedge clk);
        #1;
        checks++;
        if (pop !== 4'b0100) begin
            errors++;
            $display("FAIL single_pop: got %b want 0100", pop);
        end
        @(posedge clk);
        #1;
        checks++;
        if (pop !== 4'b0000) begin
            errors++;
            $display("FAIL single_pop_once: got %b want 0000", pop);
        end
        @(posedge clk);
        #1;
        checks++;
        if (valid_out !== 1'b1 || data_out !== 10'h278) begin
            errors++;
            $display("FAIL single_data: got %h/v%b want 278/v1",
                     data_out, valid_out);
        end
        @(negedge clk);
        ready_in = 1'b1;
        @(negedge clk);
        ready_in = 1'b0;
        m_cnt[2]++;
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL single_release: valid_out=%b want 0", valid_out);
        end
        read_count(2, d, v);
        checks++;
        if (d !== 5'd1 || v !== 1'b1) begin
            errors++;
            $display("FAIL single_count: got %0d/v%b want 1/v1", d, v);
        end
    endtask

    task automatic test_round_robin();
        logic [W-1:0] wds [NP];
        wds[0] = 10'h0A6;
        wds[1] = 10'h145;
        wds[2] = 10'h278;
        wds[3] = 10'h389;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            for (int k = 0; k < NP; k++) fq[k].push_back(wds[k]);
            build_expected();
            drain(NP, 1'b0);
        end
        check_counters("rr");
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        int n;
        @(negedge clk);
        fq[1].push_back(W'($urandom));
        build_expected();
        req = 1'b1;
        idx = 2'd1;
        n = 0;
        while (!valid_out && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!valid_out || data_out !== exp_word[0]) begin
            errors++;
            $display("FAIL bp_start: got %h/v%b want %h/v1",
                     data_out, valid_out, exp_word[0]);
        end
        held = data_out;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (data_out !== held || valid_out !== 1'b1 || pop !== '0 ||
                data !== CW'(m_cnt[1])) begin
                errors++;
                $display("FAIL bp_hold: do=%h vo=%b pop=%b cnt=%0d want %h/1/0/%0d",
                         data_out, valid_out, pop, data, held, m_cnt[1]);
            end
        end
        ready_in = 1'b1;
        @(negedge clk);
        ready_in = 1'b0;
        checks++;
        if (data !== CW'(m_cnt[1])) begin
            errors++;
            $display("FAIL bp_pre_inc: cnt=%0d want %0d", data, m_cnt[1]);
        end
        m_cnt[1]++;
        @(negedge clk);
        checks++;
        if (data !== CW'(m_cnt[1]) || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL bp_inc: cnt=%0d vo=%b want %0d/0",
                     data, valid_out, m_cnt[1]);
        end
        req = 1'b0;
        exp_port.delete();
        exp_word.delete();
        exp_hs_port.delete();
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            n = 0;
            for (int k = 0; k < NP; k++) begin
                int c = $urandom_range(0, 4);
                for (int j = 0; j < c; j++) fq[k].push_back(W'($urandom));
                n += c;
            end
            build_expected();
            drain(n, 1'b1);
        end
        check_counters("rand");
    endtask

    task automatic test_mid_reset();
        int n;
        do_reset();
        @(negedge clk);
        fq[2].push_back(W'($urandom));
        build_expected();
        drain(1, 1'b0);
        @(negedge clk);
        fq[2].push_back(W'($urandom));
        req = 1'b1;
        idx = 2'd2;
        n = 0;
        while (!valid_out && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!valid_out || data !== 5'd1) begin
            errors++;
            $display("FAIL mid_setup: vo=%b cnt=%0d want 1/1", valid_out, data);
        end
        @(posedge clk);
        #3;
        reset_L = 1'b0;
        #1;
        checks++;
        if (valid_out !== 1'b0 || data_out !== '0 || pop !== '0 ||
            data !== '0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: vo=%b do=%h pop=%b d=%0d v=%b want 0",
                     valid_out, data_out, pop, data, valid);
        end
        model_clear();
        @(negedge clk);
        req = 1'b0;
        reset_L = 1'b1;
        fq[3].push_back(W'($urandom));
        fq[2].push_back(W'($urandom));
        fq[0].push_back(W'($urandom));
        build_expected();
        drain(3, 1'b0);
        check_counters("mid");
    endtask

    task automatic test_saturation();
        do_reset();
        @(negedge clk);
        for (int j = 0; j < 33; j++) fq[1].push_back(W'($urandom));
        build_expected();
        drain(33, 1'b0);
        checks++;
        if (m_cnt[1] != CMAX) begin
            errors++;
            $display("FAIL sat_model: got %0d want %0d", m_cnt[1], CMAX);
        end
        check_counters("sat");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_random();
        test_mid_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
